// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types and constants: fetch FSM states, reset vector, opcode/funct encodings.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADDU    = 6'h21;

endpackage

// File: rtl/mips_cpu_instr_split.sv
// Combinational splitter of a 32-bit MIPS instruction word into its R/I/J-type fields.
module mips_cpu_instr_split (
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [5:0]  funct,
    output logic [15:0] offset,
    output logic [25:0] target
);

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sa     = instr[10:6];
    assign funct  = instr[5:0];
    assign offset = instr[15:0];
    assign target = instr[25:0];

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch stage: FETCH -> WAIT -> HOLD loop over an Avalon-style read bus, halts at HALT_ADDR.
// Optional bus-timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module mips_cpu_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [5:0]  funct,
    output logic [15:0] offset,
    output logic [25:0] target,
    output logic        instr_valid,
    output logic        pc_en,
    output logic        active,
    output logic        fetch_err
);

    fetch_state_t state_q;
    logic [31:0]  addr_q;
    logic         read_q;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic         active_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
    logic       err_q;
`else
    logic       unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            addr_q     <= '0;
            read_q     <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (pc == HALT_ADDR) begin
                        state_q  <= HALT;
                        active_q <= 1'b0;
                    end else begin
                        addr_q  <= pc;
                        read_q  <= 1'b1;
                        state_q <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (!mem_waitrequest) begin
                        instr_q <= mem_readdata;
                        read_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Timeout fires on the TIMEOUT_CYCLES-th stalled cycle.
                    else if (wait_cnt_q == TIMEOUT_LAST) begin
                        read_q   <= 1'b0;
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                HOLD: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                HALT: begin
                    read_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    active_q <= 1'b0;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign mem_address    = addr_q;
    assign mem_read       = read_q;
    assign mem_byteenable = 4'hF;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign active         = active_q;
    assign pc_en          = (state_q == HOLD) && !stall;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    mips_cpu_instr_split u_split (
        .instr  (instr_q),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .sa     (sa),
        .funct  (funct),
        .offset (offset),
        .target (target)
    );

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed self-checking bench for mips_cpu_fetch; checks occur 1 time unit after each rising edge.
module tb_mips_cpu_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] offset;
    logic [25:0] target;
    logic        instr_valid;
    logic        pc_en;
    logic        active;
    logic        fetch_err;

    int n_assert = 0;
    int n_fail   = 0;

    mips_cpu_fetch #(
        .HALT_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .stall           (stall),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr           (instr),
        .opcode          (opcode),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .sa              (sa),
        .funct           (funct),
        .offset          (offset),
        .target          (target),
        .instr_valid     (instr_valid),
        .pc_en           (pc_en),
        .active          (active),
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b0;
        pc              = 32'hBFC0_0000;
        stall           = 1'b0;
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h0800_0010;
        tick();
        tick();

        // Reset state
        chk("rst_read",   32'(mem_read), 32'd0);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_pc_en",  32'(pc_en), 32'd0);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_err",    32'(fetch_err), 32'd0);
        chk("rst_instr",  instr, 32'h0);
        chk("rst_be",     32'(mem_byteenable), 32'hF);

        // Test 1: zero-wait fetch of j 0x10
        reset = 1'b1;
        #1;
        chk("t1_fetch_read", 32'(mem_read), 32'd0);
        tick();
        chk("t1_read",   32'(mem_read), 32'd1);
        chk("t1_addr",   mem_address, 32'hBFC0_0000);
        chk("t1_nvalid", 32'(instr_valid), 32'd0);
        chk("t1_npc_en", 32'(pc_en), 32'd0);
        tick();
        chk("t1_valid",  32'(instr_valid), 32'd1);
        chk("t1_instr",  instr, 32'h0800_0010);
        chk("t1_opcode", 32'(opcode), 32'h02);
        chk("t1_target", 32'(target), 32'h10);
        chk("t1_rdrop",  32'(mem_read), 32'd0);
        chk("t1_pc_en",  32'(pc_en), 32'd1);
        tick();
        chk("t1_pc_en_once", 32'(pc_en), 32'd0);
        chk("t1_vclear",     32'(instr_valid), 32'd0);

        // Test 2: four waitrequest cycles, pc changes ignored
        pc              = 32'h0040_0000;
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h8C22_0004;
        tick();
        pc = 32'h0040_0100;
        for (int i = 0; i < 4; i++) begin
            chk("t2_read",  32'(mem_read), 32'd1);
            chk("t2_addr",  mem_address, 32'h0040_0000);
            chk("t2_instr", instr, 32'h0800_0010);
            tick();
            pc = pc + 32'h4;
        end
        chk("t2_still_read", 32'(mem_read), 32'd1);
        chk("t2_no_valid",   32'(instr_valid), 32'd0);
        mem_waitrequest = 1'b0;
        stall           = 1'b1;
        tick();
        chk("t2_instr_cap", instr, 32'h8C22_0004);
        chk("t2_opcode",    32'(opcode), 32'h23);
        chk("t2_rs",        32'(rs), 32'd1);
        chk("t2_rt",        32'(rt), 32'd2);
        chk("t2_offset",    32'(offset), 32'h0004);

        // Test 3: HOLD under stall
        for (int i = 0; i < 5; i++) begin
            mem_readdata = 32'hDEAD_0000 + 32'(i);
            chk("t3_valid", 32'(instr_valid), 32'd1);
            chk("t3_pc_en", 32'(pc_en), 32'd0);
            chk("t3_instr", instr, 32'h8C22_0004);
            chk("t3_read",  32'(mem_read), 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("t3_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("t3_pc_en_drop", 32'(pc_en), 32'd0);
        chk("t3_vclear",     32'(instr_valid), 32'd0);

        // Unaligned pc is issued as-is; sll $8,$10,2 exercises rd/sa/funct
        pc           = 32'h0040_0102;
        mem_readdata = 32'h000A_4080;
        tick();
        chk("ua_addr", mem_address, 32'h0040_0102);
        chk("ua_read", 32'(mem_read), 32'd1);
        tick();
        chk("ua_rt",    32'(rt), 32'd10);
        chk("ua_rd",    32'(rd), 32'd8);
        chk("ua_sa",    32'(sa), 32'd2);
        chk("ua_funct", 32'(funct), 32'h00);
        tick();

        // Test 5: reset mid-WAIT
        pc              = 32'h0040_0200;
        mem_waitrequest = 1'b1;
        tick();
        chk("t5_read_pre", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_read",   32'(mem_read), 32'd0);
        chk("t5_valid",  32'(instr_valid), 32'd0);
        chk("t5_active", 32'(active), 32'd1);
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'hDEAD_BEEF;
        stall           = 1'b1;
        tick();
        chk("t5_instr", instr, 32'h0);
        chk("t5_valid2", 32'(instr_valid), 32'd0);

        // Test 4: halt at pc==0
        pc    = 32'h0000_0000;
        stall = 1'b0;
        reset = 1'b1;
        tick();
        chk("t4_active", 32'(active), 32'd0);
        chk("t4_read",   32'(mem_read), 32'd0);
        for (int i = 0; i < 4; i++) begin
            stall = ~stall;
            pc    = 32'h0040_0000;
            tick();
            chk("t4_halt_active", 32'(active), 32'd0);
            chk("t4_halt_read",   32'(mem_read), 32'd0);
            chk("t4_halt_pc_en",  32'(pc_en), 32'd0);
            chk("t4_halt_valid",  32'(instr_valid), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("t4_reset_active", 32'(active), 32'd1);
        tick();

        // Test 6: stuck waitrequest
        pc              = 32'hBFC0_0000;
        stall           = 1'b0;
        mem_waitrequest = 1'b1;
        reset           = 1'b1;
        tick();
        chk("t6_read", 32'(mem_read), 32'd1);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        chk("t6_pre_err",    32'(fetch_err), 32'd0);
        chk("t6_pre_active", 32'(active), 32'd1);
        tick();
        chk("t6_err",    32'(fetch_err), 32'd1);
        chk("t6_active", 32'(active), 32'd0);
        chk("t6_rdrop",  32'(mem_read), 32'd0);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("t6_err",    32'(fetch_err), 32'd0);
        chk("t6_active", 32'(active), 32'd1);
        chk("t6_read2",  32'(mem_read), 32'd1);
        chk("t6_addr",   mem_address, 32'hBFC0_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
